// File: rtl/tri_row_server_if.sv
// Handshake bundle for tri_row_server: load, row-request, column-capture and readback channels.
// The DUT uses the slave modport; the driving environment uses master.
interface tri_row_server_if #(
    parameter int SIZE = 16
);
    localparam int AW = $clog2(SIZE);

    logic [SIZE*128-1:0] ld_row_i;
    logic [AW-1:0]       ld_addr_i;
    logic                ld_valid_i;
    logic                ld_ready_o;

    logic [AW-1:0]       req_addr_i;
    logic                req_valid_i;
    logic [SIZE*128-1:0] mat_row_o;
    logic [AW-1:0]       mat_row_addr_o;
    logic                mat_row_valid_o;

    logic [2*SIZE*64-1:0] inv_col_i;
    logic [AW-1:0]        inv_col_addr_i;
    logic                 inv_col_valid_i;
    logic                 inv_col_ready_o;

    logic [AW-1:0]       rd_addr_i;
    logic                rd_valid_i;
    logic [SIZE*128-1:0] rd_row_o;
    logic                rd_valid_o;
    logic                clear_i;
    logic                done_o;
    logic                busy_o;

    modport slave (
        input  ld_row_i, ld_addr_i, ld_valid_i,
        output ld_ready_o,
        input  req_addr_i, req_valid_i,
        output mat_row_o, mat_row_addr_o, mat_row_valid_o,
        input  inv_col_i, inv_col_addr_i, inv_col_valid_i,
        output inv_col_ready_o,
        input  rd_addr_i, rd_valid_i,
        output rd_row_o, rd_valid_o,
        input  clear_i,
        output done_o, busy_o
    );

    modport master (
        output ld_row_i, ld_addr_i, ld_valid_i,
        input  ld_ready_o,
        output req_addr_i, req_valid_i,
        input  mat_row_o, mat_row_addr_o, mat_row_valid_o,
        output inv_col_i, inv_col_addr_i, inv_col_valid_i,
        input  inv_col_ready_o,
        output rd_addr_i, rd_valid_i,
        input  rd_row_o, rd_valid_o,
        output clear_i,
        input  done_o, busy_o
    );
endinterface

// File: rtl/tri_row_server.sv
// Complex-matrix row server: loads a source matrix by rows, serves rows on request, captures result
// columns (transposed into rows) and reads result rows back. Option: TRI_ROW_SERVER_MASK_EN zeroes j>i.
module tri_row_server #(
    parameter int SIZE = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    tri_row_server_if.slave bus
);
    localparam int AW = $clog2(SIZE);
    localparam logic [SIZE-1:0] ALL_ROWS = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SERVE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [SIZE-1:0]     ld_bits_q, ld_bits_d;
    logic [SIZE-1:0]     col_bits_q, col_bits_d;
    logic                ld_fire, cap_fire;
    logic                req_fire, rd_fire;
    logic [SIZE*128-1:0] ld_row_store;
    logic [SIZE*128-1:0] res_row_sel;

    logic [SIZE*128-1:0] src_q [SIZE];
    logic [127:0]        res_q [SIZE][SIZE];

    logic                mat_row_valid_q;
    logic [SIZE*128-1:0] mat_row_q;
    logic [AW-1:0]       mat_row_addr_q;
    logic                rd_valid_q;
    logic [SIZE*128-1:0] rd_row_q;

    // clear wins over any same-cycle beat, so the beat is neither stored nor counted
    assign ld_fire  = bus.ld_valid_i & bus.ld_ready_o & ~bus.clear_i;
    assign cap_fire = bus.inv_col_valid_i & bus.inv_col_ready_o & ~bus.clear_i;
    assign req_fire = bus.req_valid_i & (state_q == S_SERVE) & ~bus.clear_i;
    assign rd_fire  = bus.rd_valid_i & (state_q == S_DONE) & ~bus.clear_i;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_elem
`ifdef TRI_ROW_SERVER_MASK_EN
            assign ld_row_store[gi*128 +: 128] =
                (AW'(gi) > bus.ld_addr_i) ? 128'b0 : bus.ld_row_i[gi*128 +: 128];
`else
            assign ld_row_store[gi*128 +: 128] = bus.ld_row_i[gi*128 +: 128];
`endif
            assign res_row_sel[gi*128 +: 128] = res_q[bus.rd_addr_i][gi];
        end
    endgenerate

    always_comb begin
        ld_bits_d  = ld_bits_q;
        col_bits_d = col_bits_q;
        if (bus.clear_i) begin
            ld_bits_d  = '0;
            col_bits_d = '0;
        end else begin
            if (ld_fire)  ld_bits_d[bus.ld_addr_i]       = 1'b1;
            if (cap_fire) col_bits_d[bus.inv_col_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ld_bits_q  <= '0;
            col_bits_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_bits_q  <= ld_bits_d;
            col_bits_q <= col_bits_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (ld_fire) state_d = (ld_bits_d == ALL_ROWS) ? S_SERVE : S_LOAD;
                S_LOAD:  if (ld_bits_d == ALL_ROWS) state_d = S_SERVE;
                S_SERVE: if (col_bits_d == ALL_ROWS) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // ld_ready is gated by reset so the first accepting cycle is the one after release
    always_comb begin
        bus.ld_ready_o      = ((state_q == S_IDLE) | (state_q == S_LOAD)) & ~rst_i;
        bus.inv_col_ready_o = (state_q == S_SERVE);
        bus.busy_o          = (state_q == S_LOAD) | (state_q == S_SERVE);
        bus.done_o          = (state_q == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (ld_fire) src_q[bus.ld_addr_i] <= ld_row_store;
        if (cap_fire) begin
            for (int r = 0; r < SIZE; r++) begin
                res_q[r][bus.inv_col_addr_i] <= bus.inv_col_i[r*128 +: 128];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mat_row_valid_q <= 1'b0;
            mat_row_q       <= '0;
            mat_row_addr_q  <= '0;
            rd_valid_q      <= 1'b0;
            rd_row_q        <= '0;
        end else begin
            mat_row_valid_q <= req_fire;
            rd_valid_q      <= rd_fire;
            if (req_fire) begin
                mat_row_q      <= src_q[bus.req_addr_i];
                mat_row_addr_q <= bus.req_addr_i;
            end
            if (rd_fire) rd_row_q <= res_row_sel;
        end
    end

    assign bus.mat_row_valid_o = mat_row_valid_q;
    assign bus.mat_row_o       = mat_row_q;
    assign bus.mat_row_addr_o  = mat_row_addr_q;
    assign bus.rd_valid_o      = rd_valid_q;
    assign bus.rd_row_o        = rd_row_q;
endmodule

// File: doc/tri_row_server.md
TRI_ROW_SERVER -- requirements
Module: tri_row_server

Interface
REQ-001 SHALL have parameter: SIZE, 16, matrix dimension (power of two, >=2); each element is complex {b,a}, 2x64-bit IEEE double, imaginary b in [127:64], real a in [63:0].
REQ-002 SHALL have ports, clock and reset first: clk_i  in  1  sole clock; rst_i  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports ld_row_i  in  SIZE*128  row data; ld_addr_i  in  $clog2(SIZE)  row index; ld_valid_i  in  1; ld_ready_o  out  1.
REQ-004 SHALL have ports req_addr_i  in  $clog2(SIZE)  requested row; req_valid_i  in  1  request strobe.
REQ-005 SHALL have ports mat_row_o  out  SIZE*128  served row; mat_row_addr_o  out  $clog2(SIZE)  index of served row; mat_row_valid_o  out  1.
REQ-006 SHALL have ports inv_col_i  in  2*SIZE*64  result column, element r at bits [128r+127:128r]; inv_col_addr_i  in  $clog2(SIZE); inv_col_valid_i  in  1; inv_col_ready_o  out  1.
REQ-007 SHALL have ports rd_addr_i  in  $clog2(SIZE); rd_valid_i  in  1; rd_row_o  out  SIZE*128  result row; rd_valid_o  out  1; clear_i  in  1; done_o  out  1; busy_o  out  1.

Function
REQ-008 SHALL implement FSM IDLE->LOAD->SERVE->DONE; IDLE->LOAD on first accepted load beat; LOAD->SERVE when all SIZE distinct rows have been written; SERVE->DONE when all SIZE distinct result columns have been captured; DONE->IDLE on clear_i.
REQ-009 SHALL assert ld_ready_o in IDLE and LOAD only; load handshake = ld_valid_i & ld_ready_o; writes source row ld_addr_i; per-row loaded bitmap; rewriting a row overwrites data without advancing completion.
REQ-010 SHALL, in SERVE only, register on each cycle with req_valid_i=1: mat_row_o = source row req_addr_i, mat_row_addr_o = req_addr_i, mat_row_valid_o = 1, valid exactly one cycle after the request cycle; requests in other states are ignored (mat_row_valid_o=0 next cycle).
REQ-011 SHALL hold mat_row_o and mat_row_addr_o at their last values while mat_row_valid_o=0.
REQ-012 SHALL assert inv_col_ready_o in SERVE only; capture handshake writes result[r][inv_col_addr_i] = element r of inv_col_i for all r (column-to-row transpose) and sets column bit inv_col_addr_i.
REQ-013 SHALL accept columns in any order; a repeated column overwrites its data and does not advance completion.
REQ-014 SHALL process a request and a capture in the same cycle independently and without stall.
REQ-015 SHALL capture the final column and enter DONE at the handshake edge; done_o = 1 throughout DONE.
REQ-016 SHALL, in DONE only, register rd_row_o = result row rd_addr_i with rd_valid_o = 1 exactly one cycle after rd_valid_i; otherwise rd_valid_o = 0.
REQ-017 SHALL, on clear_i in any state, enter IDLE next cycle, zero both bitmaps and all valids; stored matrix contents are not cleared; clear_i has priority over a same-cycle load/capture (the beat is dropped).
REQ-018 SHALL drive busy_o = 1 in LOAD and SERVE, 0 in IDLE and DONE.

Reset
REQ-019 SHALL, on rst_i assertion at any time including mid-operation, immediately force state IDLE, bitmaps 0, mat_row_valid_o=0, rd_valid_o=0, mat_row_o=0, mat_row_addr_o=0, rd_row_o=0, done_o=0, busy_o=0, inv_col_ready_o=0, ld_ready_o=0 during reset and 1 in the first cycle after release.
REQ-020 SHALL not reset source/result storage arrays.

Configuration
REQ-021 SHALL, when TRI_ROW_SERVER_MASK_EN is defined, store element (row i, col j) as 128'b0 for every j>i on load, guaranteeing a lower-triangular source; when undefined, store all elements unmodified.

Verification (SIZE=4)
REQ-022 SHALL cover load rows 0..3 (element(i,j)=i*4+j+1 as double real, imag 0) -> ld_ready_o drops, busy_o=1, state SERVE after 4th beat.
REQ-023 SHALL cover req_valid_i=1 with req_addr_i=2 for one cycle -> next cycle mat_row_valid_o=1, mat_row_addr_o=2, element 1 = 64'h4024000000000000 (10.0), or 0 for element 3 only under TRI_ROW_SERVER_MASK_EN.
REQ-024 SHALL cover capture columns 3,0,0,2,1 with column c element r = c*4+r -> DONE after the 5th beat only; readback rd_addr_i=1 gives element c = c*4+1.
REQ-025 SHALL cover same-cycle req_valid_i (addr 1) and capture (col 0) -> both served, row 1 valid next cycle, column bit 0 set.
REQ-026 SHALL cover rst_i asserted mid-SERVE after 2 captures -> all outputs at reset values, state IDLE; then clear_i in DONE -> IDLE, done_o=0 next cycle.
